multicycle_alu: RTL and testbench

//   Execution unit that consumes the 4-bit ALU_Control code produced by the ALU decoder.

---
 rtl/multicycle_alu.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: EX-stage execution unit driven by the 4-bit ALU decoder code.
// Single-cycle ops (add/sub/logic/shift/slt) finish one edge after start.
// MUL (shift-add) and DIV (restoring) iterate for N cycles behind busy.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while busy==0
//   ALU_Control  operation code, sampled with start
//   a, b         operands, sampled with start
//   result       registered result, held between done pulses
//   zero         registered (result == 0)
//   busy         high while MUL/DIV iterate
//   done         one-cycle completion pulse
//   error        registered; invalid code or divide-by-zero
module multicycle_alu #(
    parameter int unsigned N = 32,
    parameter int unsigned L = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [L-1:0] ALU_Control,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned SW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [L-1:0] OP_ADD_A = L'(1);
    localparam logic [L-1:0] OP_SUB_A = L'(2);
    localparam logic [L-1:0] OP_ADD_B = L'(3);
    localparam logic [L-1:0] OP_SUB_B = L'(4);
    localparam logic [L-1:0] OP_MUL   = L'(5);
    localparam logic [L-1:0] OP_DIV   = L'(6);
    localparam logic [L-1:0] OP_OR    = L'(7);
    localparam logic [L-1:0] OP_AND   = L'(8);
    localparam logic [L-1:0] OP_XOR   = L'(9);
    localparam logic [L-1:0] OP_SLL   = L'(10);
    localparam logic [L-1:0] OP_SRL   = L'(11);
    localparam logic [L-1:0] OP_SLT   = L'(12);

    logic [1:0]    state, state_n;
    logic [SW-1:0] cnt, cnt_n;
    // opa: multiplicand (shifted left) or divisor; acc: product or partial
    // remainder; q: multiplier (shifted right) or dividend/quotient.
    logic [N-1:0]  opa, opa_n;
    logic [N-1:0]  acc, acc_n;
    logic [N-1:0]  q, q_n;
    logic [N-1:0]  result_n;
    logic          zero_n, busy_n, done_n, error_n;

    logic [N-1:0]  alu_val;
    logic          alu_valid;
    logic [N-1:0]  mul_acc;
    logic [N:0]    rem_sh;
    logic          div_ge;
    logic [N-1:0]  div_acc;
    logic [N-1:0]  div_q;

    // Single-cycle operation result for the code currently on the inputs
    always_comb begin
        alu_val   = '0;
        alu_valid = 1'b1;
        case (ALU_Control)
            OP_ADD_A, OP_ADD_B: alu_val = a + b;
            OP_SUB_A, OP_SUB_B: alu_val = a - b;
            OP_OR:              alu_val = a | b;
            OP_AND:             alu_val = a & b;
            OP_XOR:             alu_val = a ^ b;
            OP_SLL:             alu_val = a << b[SW-1:0];
            OP_SRL:             alu_val = a >> b[SW-1:0];
            OP_SLT:             alu_val = N'($signed(a) < $signed(b));
            OP_MUL, OP_DIV:     alu_val = '0;
            default:            alu_valid = 1'b0;
        endcase
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        mul_acc = acc + (q[0] ? opa : '0);
        rem_sh  = {acc, q[N-1]};
        div_ge  = (rem_sh >= {1'b0, opa});
        div_acc = div_ge ? N'(rem_sh - {1'b0, opa}) : rem_sh[N-1:0];
        div_q   = {q[N-2:0], div_ge};
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        opa_n    = opa;
        acc_n    = acc;
        q_n      = q;
        result_n = result;
        zero_n   = zero;
        busy_n   = busy;
        done_n   = 1'b0;
        error_n  = error;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (ALU_Control == OP_MUL) begin
                        opa_n   = a;
                        q_n     = b;
                        acc_n   = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        state_n = S_MUL;
                    end else if (ALU_Control == OP_DIV && b != '0) begin
                        opa_n   = b;
                        q_n     = a;
                        acc_n   = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        state_n = S_DIV;
                    end else if (ALU_Control == OP_DIV) begin
                        // Divide-by-zero completes immediately with all-ones
                        result_n = '1;
                        error_n  = 1'b1;
                        done_n   = 1'b1;
                    end else begin
                        result_n = alu_valid ? alu_val : '0;
                        error_n  = ~alu_valid;
                        done_n   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_n = mul_acc;
                opa_n = opa << 1;
                q_n   = q >> 1;
                cnt_n = cnt + SW'(1);
                if (cnt == SW'(N - 1)) begin
                    result_n = mul_acc;
                    error_n  = 1'b0;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            S_DIV: begin
                acc_n = div_acc;
                q_n   = div_q;
                cnt_n = cnt + SW'(1);
                if (cnt == SW'(N - 1)) begin
                    result_n = div_q;
                    error_n  = 1'b0;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        if (done_n) zero_n = (result_n == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            opa    <= '0;
            acc    <= '0;
            q      <= '0;
            result <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            opa    <= opa_n;
            acc    <= acc_n;
            q      <= q_n;
            result <= result_n;
            zero   <= zero_n;
            busy   <= busy_n;
            done   <= done_n;
            error  <= error_n;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed-vector bench for multicycle_alu (N=32).
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_alu #(.N(32), .L(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ALU_Control(alu_control),
        .a          (a),
        .b          (b),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Present a request during the current cycle; returns #1 after the accepting edge
    task automatic issue(input logic [3:0] code, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1; alu_control = code; a = va; b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Single-cycle op: issue and check the completion registers right after the edge
    task automatic single_op(input string name, input logic [3:0] code,
                             input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] exp_r, input logic exp_err);
        issue(code, va, vb);
        n_checks++; if (done !== 1'b1)     $display("FAIL %s_done: got %b expected 1", name, done); else n_pass++;
        n_checks++; if (result !== exp_r)  $display("FAIL %s_result: got %h expected %h", name, result, exp_r); else n_pass++;
        n_checks++; if (zero !== (exp_r == 32'h0)) $display("FAIL %s_zero: got %b expected %b", name, zero, exp_r == 32'h0); else n_pass++;
        n_checks++; if (error !== exp_err) $display("FAIL %s_error: got %b expected %b", name, error, exp_err); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL %s_busy: got %b expected 0", name, busy); else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; alu_control = 4'h0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
        n_checks++; if (zero !== 1'b1)    $display("FAIL reset_zero: got %b expected 1", zero); else n_pass++;
        n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0)   $display("FAIL reset_error: got %b expected 0", error); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_cycle;
        single_op("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0)    $display("FAIL add_done_drop: got %b expected 0", done); else n_pass++;
        n_checks++; if (result !== 32'h0) $display("FAIL add_hold: got %h expected 0", result); else n_pass++;
        single_op("slt_neg",  4'b1100, 32'hFFFF_FFFE, 32'h3, 32'h1, 1'b0);
        single_op("slt_swap", 4'b1100, 32'h3, 32'hFFFF_FFFE, 32'h0, 1'b0);
        single_op("srl",      4'b1011, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0);
        single_op("sll",      4'b1010, 32'h1, 32'h1F, 32'h8000_0000, 1'b0);
        single_op("sub2",     4'b0010, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0);
        single_op("sub4",     4'b0100, 32'h10, 32'h3, 32'h0000_000D, 1'b0);
        single_op("add3",     4'b0011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);
        single_op("or",       4'b0111, 32'hF000_000F, 32'h0FF0_0000, 32'hFFF0_000F, 1'b0);
        single_op("and",      4'b1000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
    endtask

    // Long op: count busy cycles, optionally poke a start mid-operation
    task automatic run_long(input string name, input logic [3:0] code,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] exp_r, input logic poke);
        int cyc = 0;
        int early_done = 0;
        issue(code, va, vb);
        n_checks++; if (busy !== 1'b1) $display("FAIL %s_busy_set: got %b expected 1", name, busy); else n_pass++;
        while (busy === 1'b1 && cyc < 100) begin
            if (done !== 1'b0) early_done++;
            if (poke && cyc == 5) begin
                @(negedge clk);
                start = 1'b1; alu_control = 4'b0001; a = 32'h1; b = 32'h1;
            end else if (cyc == 8) begin
                @(negedge clk);
                a = 32'hDEAD_BEEF; b = 32'h0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        n_checks++; if (cyc != 32)       $display("FAIL %s_busy_cycles: got %0d expected 32", name, cyc); else n_pass++;
        n_checks++; if (early_done != 0) $display("FAIL %s_early_done: got %0d expected 0", name, early_done); else n_pass++;
        n_checks++; if (done !== 1'b1)   $display("FAIL %s_done: got %b expected 1", name, done); else n_pass++;
        n_checks++; if (result !== exp_r) $display("FAIL %s_result: got %h expected %h", name, result, exp_r); else n_pass++;
        n_checks++; if (error !== 1'b0)  $display("FAIL %s_error: got %b expected 0", name, error); else n_pass++;
    endtask

    task automatic test_mul;
        run_long("mul", 4'b0101, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL mul_no_queued_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mul_idle_after: got %b expected 0", busy); else n_pass++;
        run_long("mul_big", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_long("div", 4'b0110, 32'd100, 32'd7, 32'd14, 1'b0);
        // Issued in the done cycle of the divide
        single_op("div_by_zero", 4'b0110, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_long("div_big", 4'b0110, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0);
        single_op("after_div_add", 4'b0001, 32'd2, 32'd3, 32'd5, 1'b0);
    endtask

    task automatic test_invalid;
        single_op("inv_1110", 4'b1110, 32'h1234, 32'h5678, 32'h0, 1'b1);
        single_op("xor",      4'b1001, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0);
        single_op("inv_0000", 4'b0000, 32'h1, 32'h1, 32'h0, 1'b1);
        single_op("inv_1111", 4'b1111, 32'h1, 32'h1, 32'h0, 1'b1);
        single_op("xor2",     4'b1001, 32'hAAAA_5555, 32'h0000_FFFF, 32'hAAAA_AAAA, 1'b0);
    endtask

    task automatic test_reset_abort;
        int late_done = 0;
        issue(4'b0101, 32'h3, 32'h5);
        repeat (9) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0)    $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (result !== 32'h0) $display("FAIL abort_result: got %h expected 0", result); else n_pass++;
        n_checks++; if (zero !== 1'b1)    $display("FAIL abort_zero: got %b expected 1", zero); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) late_done++;
        end
        n_checks++; if (late_done != 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", late_done); else n_pass++;
        single_op("abort_add", 4'b0001, 32'd40, 32'd2, 32'd42, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_back_to_back();
        test_invalid();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
